pwm_carrier_compare: RTL

- PWM carrier counter and compare stage. It generates the up/down/triangular carrier, compares it against the masked (shadowed) compare value, and drives the PWM output.
- It produces the `mask_event` pulse that tells the upstream shadow-register stage when to load a new compare value. Events are at carrier zero and/or peak, per `mask_mode`.
- It is the stage directly downstream of the compare shadow register. Its `mask_event` output feeds back into that register.

---
 rtl/PKG_pwm.sv | 26 ++
 rtl/pwm_deadtime.sv | 48 ++++
 rtl/pwm_carrier_compare.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/PKG_pwm.sv
// Shared PWM types: on/off control, carrier shape and shadow-load mask selection.
// Also provides the default carrier width macro PWMCOUNT_WIDTH.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

package PKG_pwm;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  typedef enum logic [1:0] {
    CAR_UP     = 2'd0,
    CAR_DOWN   = 2'd1,
    CAR_UPDOWN = 2'd2
  } _carrier_mode;

  typedef enum logic [1:0] {
    MASK_ZERO = 2'd0,
    MASK_PEAK = 2'd1,
    MASK_BOTH = 2'd2
  } _mask_mode;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary high/low driver pair for one PWM channel; each side turns on only
// after the input has been stable for deadtime clocks and turns off immediately.
module pwm_deadtime #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] deadtime,
  output logic            pwm_h,
  output logic            pwm_l
);

  localparam logic [DT_W-1:0] DT_ONE = DT_W'(1);
  localparam logic [DT_W-1:0] DT_MAX = '1;

  logic            prev;
  logic            active;
  logic [DT_W-1:0] held;
  logic [DT_W-1:0] elapsed;
  logic            settled;

  // elapsed is the number of clocks pwm_in has held its current level
  always_comb begin
    elapsed = (pwm_in != prev) ? '0 : held;
    settled = (elapsed >= deadtime);
    pwm_h   = active & pwm_in & settled;
    pwm_l   = active & ~pwm_in & settled;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev   <= 1'b0;
      held   <= '0;
      active <= 1'b0;
    end else if (!run) begin
      prev   <= 1'b0;
      held   <= '0;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      prev   <= pwm_in;
      held   <= (elapsed == DT_MAX) ? elapsed : elapsed + DT_ONE;
    end
  end

endmodule

// File: rtl/pwm_carrier_compare.sv
// Carrier counter, compare stage and shadow-load event generator for one PWM channel.
// Optional complementary dead-time outputs are built when PWM_DEADTIME_EN is defined.
module pwm_carrier_compare
  import PKG_pwm::*;
#(
  parameter int CNT_W = `PWMCOUNT_WIDTH,
  parameter int PRE_W = 8
`ifdef PWM_DEADTIME_EN
  ,
  parameter int DT_W = 8
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  _pwm_onoff    pwm_onoff,
  input  _carrier_mode carrier_mode,
  input  _mask_mode    mask_mode,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] compare,
  output logic [CNT_W-1:0] count,
  output logic         dir,
  output logic         mask_event,
  output logic         pwm_out
`ifdef PWM_DEADTIME_EN
  ,
  input  logic [DT_W-1:0] deadtime,
  output logic         pwm_h,
  output logic         pwm_l
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic [PRE_W-1:0] pre_cnt, pre_next;
  logic [CNT_W-1:0] inc, dec, car_next, count_next;
  logic             car_dir, dir_next;
  logic             running, tick, zero_hit, peak_hit;
  logic             event_next, pwm_next;

  // State register: carrier, direction, prescaler and the registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      dir        <= 1'b1;
      pre_cnt    <= '0;
      mask_event <= 1'b0;
      pwm_out    <= 1'b0;
    end else begin
      count      <= count_next;
      dir        <= dir_next;
      pre_cnt    <= pre_next;
      mask_event <= event_next;
      pwm_out    <= pwm_next;
    end
  end

  // Next-state: the >= on the prescaler keeps ticking sane if prescale shrinks mid-count
  always_comb begin
    running  = (pwm_onoff == PWM_ON);
    tick     = running && (pre_cnt >= prescale);
    inc      = count + CNT_ONE;
    dec      = count - CNT_ONE;
    car_next = count;
    car_dir  = dir;
    case (carrier_mode)
      CAR_DOWN: begin
        car_dir  = 1'b0;
        car_next = (count == '0 || count > period) ? period : dec;
      end
      CAR_UPDOWN: begin
        if (period == '0) begin
          car_next = '0;
          car_dir  = 1'b1;
        end else if (count > period) begin
          car_next = period;
          car_dir  = 1'b0;
        end else if ((dir && count != period) || count == '0) begin
          car_next = inc;
          car_dir  = (inc != period);
        end else begin
          car_next = dec;
          car_dir  = (dec == '0);
        end
      end
      default: begin
        car_dir  = 1'b1;
        car_next = (count >= period) ? '0 : inc;
      end
    endcase

    if (!running) begin
      pre_next   = '0;
      count_next = '0;
      dir_next   = 1'b1;
    end else if (tick) begin
      pre_next   = '0;
      count_next = car_next;
      dir_next   = car_dir;
    end else begin
      pre_next   = pre_cnt + PRE_ONE;
      count_next = count;
      dir_next   = dir;
    end
  end

  // Output decode: event and compare only move when the carrier moves
  always_comb begin
    zero_hit   = (car_next == '0);
    peak_hit   = (car_next == period);
    event_next = 1'b0;
    pwm_next   = pwm_out;
    if (!running) begin
      pwm_next = 1'b0;
    end else if (tick) begin
      pwm_next = (car_next < compare);
      case (mask_mode)
        MASK_ZERO: event_next = zero_hit;
        MASK_PEAK: event_next = peak_hit;
        MASK_BOTH: event_next = zero_hit | peak_hit;
        default:   event_next = 1'b0;
      endcase
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime #(
    .DT_W(DT_W)
  ) u_deadtime (
    .clk      (clk),
    .reset    (reset),
    .run      (running),
    .pwm_in   (pwm_out),
    .deadtime (deadtime),
    .pwm_h    (pwm_h),
    .pwm_l    (pwm_l)
  );
`endif

endmodule
